vga_char_sched: RTL and testbench

- Two-requester scheduler and Wishbone master for the VGA character peripheral.
- Each requester submits {row, col, char} jobs. The block arbitrates round-robin between requesters, validates the character, and sequences the peripheral register writes: position register, then character register.
- Sits between the system-side producers (e.g. CPU mailbox, status counter) and the VGA peripheral's Wishbone slave port, in the wb_clk_i domain.

---
 rtl/vga_char_sched.sv | 177 +++++++++++++++++
 tb/tb_vga_char_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_char_sched.sv
// rtl/vga_char_sched.sv - two-requester round-robin scheduler and Wishbone master for the VGA character peripheral
module vga_char_sched #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  POS_ADDR       = 8'h00,
  parameter logic [7:0]  CHAR_ADDR      = 8'h0C,
  parameter logic [7:0]  CHAR_MIN       = 8'h30,
  parameter logic [7:0]  CHAR_MAX       = 8'h39
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [9:0]  req0_row,
  input  logic [9:0]  req0_col,
  input  logic [7:0]  req0_char,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [9:0]  req1_row,
  input  logic [9:0]  req1_col,
  input  logic [7:0]  req1_char,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [7:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        busy_o,
  output logic        grant_o,
  output logic        done_o,
  output logic        reject_o,
  output logic        timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WR_POS, GAP, WR_CHAR, ABORT} state_t;

  state_t        state;
  logic          last_grant;
  logic [9:0]    job_row;
  logic [9:0]    job_col;
  logic [7:0]    job_char;
  logic          cache_valid;
  logic [19:0]   cache_pos;
  logic [TW-1:0] tcnt;

  logic          winner;
  logic          accept;
  logic [9:0]    acc_row;
  logic [9:0]    acc_col;
  logic [7:0]    acc_char;
  logic          char_ok;
  logic          pos_hit;
  logic          expired;

  // With both requesting, the one that did not win last time goes next.
  always_comb begin
    winner = req1_valid;
    if (req0_valid && req1_valid)
      winner = ~last_grant;
  end

  assign req0_ready = (state == IDLE) & req0_valid & ~winner;
  assign req1_ready = (state == IDLE) & req1_valid & winner;
  assign accept     = req0_ready | req1_ready;

  assign acc_row  = winner ? req1_row  : req0_row;
  assign acc_col  = winner ? req1_col  : req0_col;
  assign acc_char = winner ? req1_char : req0_char;
  assign char_ok  = (acc_char >= CHAR_MIN) && (acc_char <= CHAR_MAX);
  assign pos_hit  = cache_valid && (cache_pos == {acc_row, acc_col});
  assign expired  = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign busy_o   = (state != IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_o     <= 1'b0;
      job_row     <= '0;
      job_col     <= '0;
      job_char    <= '0;
      cache_valid <= 1'b0;
      cache_pos   <= '0;
      tcnt        <= '0;
      m_cyc_o     <= 1'b0;
      m_stb_o     <= 1'b0;
      m_we_o      <= 1'b0;
      m_adr_o     <= '0;
      m_dat_o     <= '0;
      m_sel_o     <= '0;
      done_o      <= 1'b0;
      reject_o    <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      reject_o  <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= winner;
            grant_o    <= winner;
            job_row    <= acc_row;
            job_col    <= acc_col;
            job_char   <= acc_char;
            if (!char_ok) begin
              reject_o <= 1'b1;
            end else begin
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              m_we_o  <= 1'b1;
              m_sel_o <= 4'hF;
              tcnt    <= '0;
              if (pos_hit) begin
                state   <= WR_CHAR;
                m_adr_o <= CHAR_ADDR;
                m_dat_o <= {24'b0, acc_char};
              end else begin
                state   <= WR_POS;
                m_adr_o <= POS_ADDR;
                m_dat_o <= {12'b0, acc_row, acc_col};
              end
            end
          end
        end
        WR_POS, WR_CHAR: begin
          // Ack beats a simultaneous timeout expiry.
          if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= 4'h0;
            if (state == WR_POS) begin
              cache_valid <= 1'b1;
              cache_pos   <= {job_row, job_col};
              state       <= GAP;
            end else begin
              done_o <= 1'b1;
              state  <= IDLE;
            end
          end else if (m_err_i || expired) begin
            m_cyc_o     <= 1'b0;
            m_stb_o     <= 1'b0;
            m_we_o      <= 1'b0;
            m_sel_o     <= 4'h0;
            cache_valid <= 1'b0;
            timeout_o   <= 1'b1;
            state       <= ABORT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        GAP: begin
          // The peripheral re-acks a held strobe, so the bus must drop for a cycle.
          state   <= WR_CHAR;
          m_cyc_o <= 1'b1;
          m_stb_o <= 1'b1;
          m_we_o  <= 1'b1;
          m_sel_o <= 4'hF;
          m_adr_o <= CHAR_ADDR;
          m_dat_o <= {24'b0, job_char};
          tcnt    <= '0;
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_char_sched.sv
// tb/tb_vga_char_sched.sv - self-checking bench for vga_char_sched against a job-level reference model
module tb_vga_char_sched;

  localparam int M_ACK  = 0;
  localparam int M_NONE = 1;
  localparam int M_ERR  = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [9:0]  req0_row, req0_col, req1_row, req1_col;
  logic [7:0]  req0_char, req1_char;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [7:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_ack_i, m_err_i;
  logic        busy_o, grant_o, done_o, reject_o, timeout_o;

  int n_cmp = 0;
  int n_err = 0;
  int per_mode = M_ACK;
  int stb_total = 0;
  int cyc_total = 0;
  int dual_rdy = 0;
  logic [39:0] wr_log[$];

  bit          mc_valid;
  logic [19:0] mc_pos;
  bit          m_last;

  vga_char_sched dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_row(req0_row),
    .req0_col(req0_col), .req0_char(req0_char),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_row(req1_row),
    .req1_col(req1_col), .req1_char(req1_char),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .busy_o(busy_o), .grant_o(grant_o), .done_o(done_o), .reject_o(reject_o),
    .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Peripheral with a one-cycle registered response that re-responds to a held strobe.
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_ack_i <= 1'b0;
      m_err_i <= 1'b0;
    end else begin
      m_ack_i <= (per_mode == M_ACK) && m_stb_o && !m_ack_i;
      m_err_i <= (per_mode == M_ERR) && m_stb_o && !m_err_i;
    end
  end

  always @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (m_stb_o) stb_total <= stb_total + 1;
      if (m_cyc_o) cyc_total <= cyc_total + 1;
      if (req0_ready && req1_ready) dual_rdy <= dual_rdy + 1;
      if (m_stb_o && m_ack_i) wr_log.push_back({m_adr_o, m_dat_o});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one job from whichever requester the model says should win and checks its outcome.
  task automatic job(input bit drop);
    int          exp_who, exp_k, exp_stb, k, t, base_wr, base_stb, base_cyc, nwr;
    logic [2:0]  exp_ev, ev;
    logic [9:0]  r, c;
    logic [7:0]  ch;
    logic [39:0] exp_wr[$];
    #1;
    exp_who = (req0_valid && req1_valid) ? (m_last ? 0 : 1) : (req1_valid ? 1 : 0);
    r  = exp_who ? req1_row  : req0_row;
    c  = exp_who ? req1_col  : req0_col;
    ch = exp_who ? req1_char : req0_char;
    if (ch < 8'h30 || ch > 8'h39) begin
      exp_ev = 3'b010; exp_k = 1; exp_stb = 0;
    end else if (per_mode == M_NONE) begin
      exp_ev = 3'b100; exp_k = 17; exp_stb = 16; mc_valid = 0;
    end else if (per_mode == M_ERR) begin
      exp_ev = 3'b100; exp_k = 3; exp_stb = 2; mc_valid = 0;
    end else if (mc_valid && mc_pos == {r, c}) begin
      exp_ev = 3'b001; exp_k = 3; exp_stb = 2;
      exp_wr.push_back({8'h0C, 24'b0, ch});
    end else begin
      exp_ev = 3'b001; exp_k = 6; exp_stb = 4;
      exp_wr.push_back({8'h00, 12'b0, r, c});
      exp_wr.push_back({8'h0C, 24'b0, ch});
      mc_valid = 1; mc_pos = {r, c};
    end
    m_last = exp_who[0];
    t = 0;
    while (!(req0_ready || req1_ready) && t < 60) begin
      @(negedge wb_clk_i); t++;
    end
    chk("ready_sel", {req1_ready, req0_ready}, exp_who ? 2'b10 : 2'b01);
    base_wr = wr_log.size(); base_stb = stb_total; base_cyc = cyc_total;
    @(posedge wb_clk_i);
    k = 0;
    do begin
      @(negedge wb_clk_i); k++;
      if (drop && k == 1) begin req0_valid = 0; req1_valid = 0; end
      ev = {timeout_o, reject_o, done_o};
    end while (ev == 3'b000 && k < 40);
    chk("outcome", ev, exp_ev);
    chk("latency", k, exp_k);
    chk("grant", grant_o, exp_who);
    chk("stb_cycles", stb_total - base_stb, exp_stb);
    if (exp_stb == 0) chk("cyc_cycles", cyc_total - base_cyc, 0);
    nwr = wr_log.size() - base_wr;
    chk("write_count", nwr, exp_wr.size());
    for (int i = 0; i < nwr && i < exp_wr.size(); i++)
      chk("write_adr_dat", wr_log[base_wr + i], exp_wr[i]);
  endtask

  initial begin
    int t;
    wb_rst_i = 1;
    req0_valid = 0; req1_valid = 0;
    req0_row = 0; req0_col = 0; req0_char = 0;
    req1_row = 0; req1_col = 0; req1_char = 0;
    mc_valid = 0; mc_pos = 0; m_last = 1;
    @(negedge wb_clk_i); @(negedge wb_clk_i); #1;
    chk("reset_outputs", {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o, busy_o,
                          grant_o, done_o, reject_o, timeout_o, req0_ready, req1_ready}, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 0;

    // Full position + character write, then a cached-position job.
    req0_row = 255; req0_col = 175; req0_char = 8'h31; req0_valid = 1;
    job(1);
    req0_char = 8'h35; req0_valid = 1;
    job(1);

    // Out-of-range character from requester 1.
    req1_row = 3; req1_col = 4; req1_char = 8'h41; req1_valid = 1;
    job(1);

    // Both requesters continuously valid: grants alternate starting with 0.
    req0_row = 1; req0_col = 2; req0_char = 8'h37;
    req1_row = 1; req1_col = 2; req1_char = 8'h38;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) job(0);
    req0_valid = 0; req1_valid = 0;

    // No ack: abort after the strobe budget, then the position is rewritten.
    per_mode = M_NONE;
    req0_valid = 1;
    job(1);
    @(negedge wb_clk_i);
    chk("busy_after_abort", busy_o, 0);
    per_mode = M_ACK;
    req0_valid = 1;
    job(1);

    per_mode = M_ERR;
    req1_row = 1; req1_col = 2; req1_char = 8'h30; req1_valid = 1;
    job(1);
    per_mode = M_ACK;

    for (int i = 0; i < 24; i++) begin
      int sel, md;
      sel = $urandom_range(0, 1);
      md  = $urandom_range(0, 7);
      per_mode = (md == 0) ? M_NONE : (md == 1) ? M_ERR : M_ACK;
      if (sel == 0) begin
        req0_row = 10'($urandom_range(5, 6)); req0_col = 7;
        req0_char = 8'($urandom_range(8'h2E, 8'h3B)); req0_valid = 1;
      end else begin
        req1_row = 10'($urandom_range(5, 6)); req1_col = 7;
        req1_char = 8'($urandom_range(8'h2E, 8'h3B)); req1_valid = 1;
      end
      job(1);
    end
    per_mode = M_ACK;

    // Reset while the character write strobe is up.
    req0_row = 9; req0_col = 9; req0_char = 8'h35; req0_valid = 1;
    #1;
    t = 0;
    while (!(m_stb_o && m_adr_o == 8'h0C) && t < 40) begin
      @(negedge wb_clk_i); t++;
    end
    chk("reached_wr_char", m_stb_o && m_adr_o == 8'h0C, 1);
    wb_rst_i = 1;
    #1;
    chk("async_reset_bus", {m_cyc_o, m_stb_o, busy_o}, 3'b000);
    mc_valid = 0; m_last = 1;
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    wb_rst_i = 0;
    req1_row = 9; req1_col = 9; req1_char = 8'h35; req1_valid = 1;
    #1;
    chk("first_grant_after_reset", {req1_ready, req0_ready}, 2'b01);
    req1_valid = 0;
    job(1);

    chk("dual_ready", dual_rdy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
